// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks registers FIRST_REG..LAST_REG through a spare
// register-file read port and streams each word MSB-first as bytes.
//
// state | meaning
// IDLE  | waiting for start; index parked at FIRST_REG
// LOAD  | capture rd for the current index into the shift register
// SEND  | offer shift[31:24]; shift on each accepted byte
// DONE  | one-cycle done pulse; index rewinds to FIRST_REG
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_params
    $error("regfile_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      index_q    <= FIRST_IDX;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    tx_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        shift_d    = rd;
        byte_cnt_d = 2'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) begin
          shift_d    = {shift_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Last-register test comes first so index never wraps past 31.
          if (byte_cnt_q == 2'd3) begin
            if (index_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + 5'd1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        index_d = FIRST_IDX;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ra      = index_q;
  assign tx_data = shift_q[31:24];

endmodule
